issue_age_scheduler: RTL and testbench

Slot allocator and oldest-first select scheduler for the 16-entry issue queue.
- Rename requests a slot; the block returns the index the queue writes the entry into.
- Each cycle the block picks the oldest valid entry whose operands are ready (ready_vec from the queue's ready_q AND).
- The picked index is held to execution with a valid/ack handshake; the slot is freed on ack.
- Age order is kept in an age matrix, so a reused slot index is always youngest.

---
 rtl/issue_age_scheduler.sv | 165 ++++++++++++++++
 tb/tb_issue_age_scheduler.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/issue_age_scheduler.sv
// issue_age_scheduler: slot allocator and oldest-first select scheduler for
// the issue queue. Rename takes the lowest free slot. Each cycle the oldest
// ready, unpicked entry is loaded into a registered issue slot. That slot is
// held until execution acks it, and the ack frees the queue slot. Relative age
// is kept in an age matrix, so a reused slot index is always the youngest.
//
// Ports:
//   CLK, RESET   clock (rising edge) and asynchronous active-high reset
//   FLUSH        synchronous squash of every entry
//   STALL        freeze: no alloc, no select, no free
//   alloc_req    rename wants a slot this cycle
//   alloc_ok     combinational: !full & !STALL & !FLUSH
//   alloc_idx    combinational: lowest-index free slot (0 when full)
//   ready_vec    per-slot operands-ready from the issue queue
//   issue_valid  registered: issue_idx holds a selected entry
//   issue_idx    registered selected slot
//   issue_ack    execution accepts issue_idx at this edge
//   occupied     registered valid bit per slot
//   count        registered number of valid slots
//   full         count == DEPTH
module issue_age_scheduler #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned IDX_W = 4
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             FLUSH,
  input  logic             STALL,
  input  logic             alloc_req,
  output logic             alloc_ok,
  output logic [IDX_W-1:0] alloc_idx,
  input  logic [DEPTH-1:0] ready_vec,
  output logic             issue_valid,
  output logic [IDX_W-1:0] issue_idx,
  input  logic             issue_ack,
  output logic [DEPTH-1:0] occupied,
  output logic [IDX_W:0]   count,
  output logic             full
);

  localparam int unsigned CNT_W = IDX_W + 1;

  // Lowest-index priority encoder; returns 0 for an all-zero vector.
  function automatic logic [IDX_W-1:0] lowest_idx(input logic [DEPTH-1:0] v);
    logic [IDX_W-1:0] r;
    r = '0;
    for (int i = int'(DEPTH) - 1; i >= 0; i--) begin
      if (v[i]) r = IDX_W'(i);
    end
    return r;
  endfunction

  // older_q[j][i] = 1 means slot j was allocated before slot i.
  logic [DEPTH-1:0][DEPTH-1:0] older_q, older_d;
  logic [DEPTH-1:0]            occupied_q, occupied_d;
  logic [DEPTH-1:0]            picked_q, picked_d;
  logic                        issue_valid_q, issue_valid_d;
  logic [IDX_W-1:0]            issue_idx_q, issue_idx_d;
  logic [CNT_W-1:0]            count_q, count_d;

  logic             full_w;
  logic             free_fire;
  logic             alloc_fire;
  logic             load_en;
  logic [DEPTH-1:0] free_oh;
  logic [DEPTH-1:0] cand;
  logic [DEPTH-1:0] win;
  logic [IDX_W-1:0] oldest_idx;

  assign full_w      = (count_q == CNT_W'(DEPTH));
  assign full        = full_w;
  assign occupied    = occupied_q;
  assign count       = count_q;
  assign issue_valid = issue_valid_q;
  assign issue_idx   = issue_idx_q;

  // Allocation, free and oldest-ready selection.
  always_comb begin
    alloc_ok   = ~full_w & ~STALL & ~FLUSH;
    alloc_idx  = lowest_idx(~occupied_q);
    alloc_fire = alloc_req & alloc_ok;
    free_fire  = issue_valid_q & issue_ack & ~STALL & ~FLUSH;
    free_oh    = free_fire ? (DEPTH'(1) << issue_idx_q) : '0;

    // The slot leaving this edge is never re-picked; picked_q already covers
    // the held entry, the free mask just makes that explicit.
    cand = occupied_q & ready_vec & ~picked_q & ~free_oh;

    // A candidate wins only if no other candidate is older than it.
    win = cand;
    for (int i = 0; i < int'(DEPTH); i++) begin
      for (int j = 0; j < int'(DEPTH); j++) begin
        if (cand[j] && older_q[j][i]) win[i] = 1'b0;
      end
    end
    oldest_idx = lowest_idx(win);

    load_en = (~issue_valid_q | issue_ack) & ~STALL & ~FLUSH & (|cand);
  end

  // Next-state for occupancy, age matrix, issue slot and count.
  always_comb begin
    occupied_d    = occupied_q;
    picked_d      = picked_q;
    older_d       = older_q;
    issue_valid_d = issue_valid_q;
    issue_idx_d   = issue_idx_q;
    count_d       = count_q;

    if (FLUSH) begin
      occupied_d    = '0;
      picked_d      = '0;
      older_d       = '0;
      issue_valid_d = 1'b0;
      count_d       = '0;
    end else if (!STALL) begin
      if (free_fire) begin
        occupied_d           = occupied_d & ~free_oh;
        picked_d             = picked_d & ~free_oh;
        older_d[issue_idx_q] = '0;
        for (int j = 0; j < int'(DEPTH); j++) begin
          older_d[j][issue_idx_q] = 1'b0;
        end
      end

      // New entry is younger than everything that survives this edge.
      if (alloc_fire) begin
        occupied_d[alloc_idx] = 1'b1;
        older_d[alloc_idx]    = '0;
        for (int j = 0; j < int'(DEPTH); j++) begin
          older_d[j][alloc_idx] = occupied_q[j] & ~free_oh[j];
        end
      end

      if (load_en) begin
        issue_valid_d        = 1'b1;
        issue_idx_d          = oldest_idx;
        picked_d[oldest_idx] = 1'b1;
      end else if (free_fire) begin
        issue_valid_d = 1'b0;
      end

      count_d = count_q + CNT_W'(alloc_fire) - CNT_W'(free_fire);
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      occupied_q    <= '0;
      picked_q      <= '0;
      older_q       <= '0;
      issue_valid_q <= 1'b0;
      issue_idx_q   <= '0;
      count_q       <= '0;
    end else begin
      occupied_q    <= occupied_d;
      picked_q      <= picked_d;
      older_q       <= older_d;
      issue_valid_q <= issue_valid_d;
      issue_idx_q   <= issue_idx_d;
      count_q       <= count_d;
    end
  end

endmodule

// File: tb/tb_issue_age_scheduler.sv
// tb_issue_age_scheduler: directed-vector bench for issue_age_scheduler.
// Inputs change 1 time unit after a rising edge; outputs are checked there too.
module tb_issue_age_scheduler;

  logic        CLK;
  logic        RESET;
  logic        FLUSH;
  logic        STALL;
  logic        alloc_req;
  logic        alloc_ok;
  logic [3:0]  alloc_idx;
  logic [15:0] ready_vec;
  logic        issue_valid;
  logic [3:0]  issue_idx;
  logic        issue_ack;
  logic [15:0] occupied;
  logic [4:0]  count;
  logic        full;

  int n_chk;
  int n_err;

  issue_age_scheduler #(.DEPTH(16), .IDX_W(4)) dut (
    .CLK         (CLK),
    .RESET       (RESET),
    .FLUSH       (FLUSH),
    .STALL       (STALL),
    .alloc_req   (alloc_req),
    .alloc_ok    (alloc_ok),
    .alloc_idx   (alloc_idx),
    .ready_vec   (ready_vec),
    .issue_valid (issue_valid),
    .issue_idx   (issue_idx),
    .issue_ack   (issue_ack),
    .occupied    (occupied),
    .count       (count),
    .full        (full)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%0h expected=%0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish (errors=%0d of %0d checks)", n_err, n_chk);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int ord[3];
    logic [15:0] tog[4];
    ord = '{2, 3, 0};
    tog = '{16'hFFFF, 16'h0000, 16'h0001, 16'hFFFF};
    n_chk = 0;
    n_err = 0;
    CLK = 1'b0; RESET = 1'b1; FLUSH = 1'b0; STALL = 1'b0;
    alloc_req = 1'b0; ready_vec = '0; issue_ack = 1'b0;

    // Reset release
    repeat (2) @(posedge CLK);
    #1 RESET = 1'b0;
    #1;
    check("rst_occupied", 32'(occupied), 32'h0);
    check("rst_count", 32'(count), 32'h0);
    check("rst_alloc_ok", 32'(alloc_ok), 32'h1);
    check("rst_alloc_idx", 32'(alloc_idx), 32'h0);
    check("rst_issue_valid", 32'(issue_valid), 32'h0);
    check("rst_full", 32'(full), 32'h0);

    // Out-of-order readiness
    alloc_req = 1'b1;
    for (int k = 0; k < 3; k++) begin
      check("ooo_alloc_idx", 32'(alloc_idx), k);
      tick();
    end
    alloc_req = 1'b0;
    check("ooo_occupied", 32'(occupied), 32'h7);
    check("ooo_count", 32'(count), 32'h3);
    check("ooo_idle", 32'(issue_valid), 32'h0);
    ready_vec = 16'h0004;
    tick();
    check("ooo_valid2", 32'(issue_valid), 32'h1);
    check("ooo_idx2", 32'(issue_idx), 32'h2);
    issue_ack = 1'b1;
    ready_vec = 16'h0007;
    tick();
    check("ooo_idx0", 32'(issue_idx), 32'h0);
    check("ooo_valid0", 32'(issue_valid), 32'h1);
    check("ooo_occ_after2", 32'(occupied), 32'h3);
    check("ooo_count2", 32'(count), 32'h2);
    tick();
    check("ooo_idx1", 32'(issue_idx), 32'h1);
    check("ooo_count1", 32'(count), 32'h1);
    tick();
    check("ooo_drained_valid", 32'(issue_valid), 32'h0);
    check("ooo_drained_count", 32'(count), 32'h0);
    check("ooo_drained_occ", 32'(occupied), 32'h0);
    issue_ack = 1'b0;
    ready_vec = '0;

    // Slot reuse: reallocated slot 0 becomes the youngest
    alloc_req = 1'b1;
    repeat (4) tick();
    alloc_req = 1'b0;
    check("reuse_occ4", 32'(occupied), 32'hF);
    ready_vec = 16'h0001;
    tick();
    check("reuse_idx0", 32'(issue_idx), 32'h0);
    issue_ack = 1'b1;
    ready_vec = '0;
    tick();
    check("reuse_free_valid", 32'(issue_valid), 32'h0);
    check("reuse_free_occ", 32'(occupied), 32'hE);
    check("reuse_free_count", 32'(count), 32'h3);
    issue_ack = 1'b0;
    alloc_req = 1'b1;
    #1;
    check("reuse_alloc_idx", 32'(alloc_idx), 32'h0);
    tick();
    alloc_req = 1'b0;
    check("reuse_occ_again", 32'(occupied), 32'hF);
    check("reuse_count4", 32'(count), 32'h4);
    ready_vec = 16'h000F;
    tick();
    check("reuse_first", 32'(issue_idx), 32'h1);
    issue_ack = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      check("reuse_order", 32'(issue_idx), ord[k]);
    end
    tick();
    check("reuse_end_valid", 32'(issue_valid), 32'h0);
    check("reuse_end_count", 32'(count), 32'h0);
    issue_ack = 1'b0;
    ready_vec = '0;

    // Full, then same-edge ack + refused alloc
    alloc_req = 1'b1;
    repeat (16) tick();
    check("full_count", 32'(count), 32'd16);
    check("full_flag", 32'(full), 32'h1);
    check("full_alloc_ok", 32'(alloc_ok), 32'h0);
    check("full_alloc_idx", 32'(alloc_idx), 32'h0);
    alloc_req = 1'b0;
    ready_vec = 16'h0020;
    tick();
    check("full_issue_valid", 32'(issue_valid), 32'h1);
    check("full_issue_idx", 32'(issue_idx), 32'h5);
    issue_ack = 1'b1;
    alloc_req = 1'b1;
    ready_vec = '0;
    tick();
    check("simul_count", 32'(count), 32'd15);
    check("simul_full", 32'(full), 32'h0);
    check("simul_occ", 32'(occupied), 32'hFFDF);
    check("simul_valid", 32'(issue_valid), 32'h0);
    issue_ack = 1'b0;
    alloc_req = 1'b0;
    #1;
    check("simul_next_idx", 32'(alloc_idx), 32'h5);
    check("simul_next_ok", 32'(alloc_ok), 32'h1);
    alloc_req = 1'b1;
    tick();
    alloc_req = 1'b0;
    check("refill_count", 32'(count), 32'd16);

    // Handshake hold and STALL during ack
    ready_vec = 16'h0020;
    tick();
    check("hold_load_idx", 32'(issue_idx), 32'h5);
    for (int k = 0; k < 4; k++) begin
      ready_vec = tog[k];
      tick();
      check("hold_idx", 32'(issue_idx), 32'h5);
      check("hold_valid", 32'(issue_valid), 32'h1);
    end
    STALL = 1'b1;
    issue_ack = 1'b1;
    #1;
    check("stall_alloc_ok", 32'(alloc_ok), 32'h0);
    tick();
    check("stall_valid", 32'(issue_valid), 32'h1);
    check("stall_idx", 32'(issue_idx), 32'h5);
    check("stall_count", 32'(count), 32'd16);
    check("stall_occ", 32'(occupied), 32'hFFFF);
    STALL = 1'b0;
    ready_vec = '0;
    tick();
    check("ack_after_stall_valid", 32'(issue_valid), 32'h0);
    check("ack_after_stall_count", 32'(count), 32'd15);
    check("ack_after_stall_occ", 32'(occupied), 32'hFFDF);
    issue_ack = 1'b0;

    // FLUSH with 6 entries and a held issue
    FLUSH = 1'b1;
    tick();
    FLUSH = 1'b0;
    check("flush0_count", 32'(count), 32'h0);
    alloc_req = 1'b1;
    repeat (6) tick();
    alloc_req = 1'b0;
    ready_vec = 16'h0001;
    tick();
    check("preflush_valid", 32'(issue_valid), 32'h1);
    check("preflush_count", 32'(count), 32'd6);
    FLUSH = 1'b1;
    alloc_req = 1'b1;
    issue_ack = 1'b1;
    #1;
    check("flush_alloc_ok", 32'(alloc_ok), 32'h0);
    tick();
    FLUSH = 1'b0;
    alloc_req = 1'b0;
    issue_ack = 1'b0;
    ready_vec = '0;
    check("flush_occ", 32'(occupied), 32'h0);
    check("flush_count", 32'(count), 32'h0);
    check("flush_valid", 32'(issue_valid), 32'h0);

    // Allocate-to-issue latency, then asynchronous reset mid-handshake
    ready_vec = 16'hFFFF;
    alloc_req = 1'b1;
    tick();
    alloc_req = 1'b0;
    check("lat_not_same_edge", 32'(issue_valid), 32'h0);
    check("lat_occ", 32'(occupied), 32'h1);
    tick();
    check("lat_valid", 32'(issue_valid), 32'h1);
    check("lat_idx", 32'(issue_idx), 32'h0);
    alloc_req = 1'b1;
    tick();
    alloc_req = 1'b0;
    issue_ack = 1'b1;
    tick();
    issue_ack = 1'b0;
    check("b2b_idx1", 32'(issue_idx), 32'h1);
    #2 RESET = 1'b1;
    #1;
    check("arst_valid", 32'(issue_valid), 32'h0);
    check("arst_idx", 32'(issue_idx), 32'h0);
    check("arst_occ", 32'(occupied), 32'h0);
    check("arst_count", 32'(count), 32'h0);
    RESET = 1'b0;
    ready_vec = '0;
    #1;
    check("arst_alloc_ok", 32'(alloc_ok), 32'h1);
    check("arst_alloc_idx", 32'(alloc_idx), 32'h0);
    tick();
    check("arst_stays_idle", 32'(issue_valid), 32'h0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
